// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - multi-cycle fetch/decode/execute control FSM with return stack
module control_sequencer #(
    parameter int DATA_W      = 8,
    parameter int OPC_W       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [OPC_W+2*DATA_W-1:0] instr_word,
    input  logic                      mem_ready,
    input  logic [3:0]                flags,
    input  logic [DATA_W-1:0]         pc_val,
    output logic                      mar_load,
    output logic                      ir_load,
    output logic                      pc_inc,
    output logic                      pc_load,
    output logic [DATA_W-1:0]         pc_load_val,
    output logic                      reg_rd_en,
    output logic [DATA_W-1:0]         rd_addr1,
    output logic [DATA_W-1:0]         rd_addr2,
    output logic                      reg_wr_en,
    output logic [DATA_W-1:0]         wr_addr,
    output logic [1:0]                wr_sel,
    output logic [DATA_W-1:0]         wr_imm,
    output logic                      alu_en,
    output logic [OPC_W-1:0]          alu_sel,
    output logic                      halted,
    output logic                      fault
);
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    localparam logic [OPC_W-1:0] OP_NOP    = OPC_W'(8'h00);
    localparam logic [OPC_W-1:0] OP_LDI    = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_ALU_LO = OPC_W'(8'h03);
    localparam logic [OPC_W-1:0] OP_CMP    = OPC_W'(8'h18);
    localparam logic [OPC_W-1:0] OP_JMP    = OPC_W'(8'h19);
    localparam logic [OPC_W-1:0] OP_MOV    = OPC_W'(8'h20);
    localparam logic [OPC_W-1:0] OP_CALL   = OPC_W'(8'h21);
    localparam logic [OPC_W-1:0] OP_RET    = OPC_W'(8'h22);
    localparam logic [OPC_W-1:0] OP_JZ     = OPC_W'(8'h23);
    localparam logic [OPC_W-1:0] OP_JNZ    = OPC_W'(8'h24);
    localparam logic [OPC_W-1:0] OP_JG     = OPC_W'(8'h25);
    localparam logic [OPC_W-1:0] OP_JL     = OPC_W'(8'h26);
    localparam logic [OPC_W-1:0] OP_HALT   = OPC_W'(8'h3F);

    typedef enum logic [3:0] {
        S_FETCH_0, S_FETCH_1, S_DECODE, S_RD, S_EX, S_WB, S_JUMP, S_HALT, S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [OPC_W-1:0]    opc_q, opc_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, target_q, target_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic [DATA_W-1:0]   stack_q [STACK_DEPTH];
    logic [DATA_W-1:0]   stack_d [STACK_DEPTH];

    logic [OPC_W-1:0]    dec_opc;
    logic [DATA_W-1:0]   dec_a, dec_b;
    logic                flag_z, flag_n, flag_v, unused_flag_c;
    logic [IDX_W-1:0]    push_idx, pop_idx;

    assign {dec_opc, dec_a, dec_b} = instr_word;
    assign {flag_v, flag_n, unused_flag_c, flag_z} = flags;
    assign push_idx = sp_q[IDX_W-1:0];
    assign pop_idx  = IDX_W'(sp_q - SP_W'(1));

    function automatic logic is_alu(input logic [OPC_W-1:0] op);
        return (op >= OP_ALU_LO) && (op <= OP_CMP);
    endfunction

    always_comb begin
        state_d  = state_q;
        opc_d    = opc_q;
        a_d      = a_q;
        b_d      = b_q;
        target_d = target_q;
        sp_d     = sp_q;
        stack_d  = stack_q;
        case (state_q)
            S_FETCH_0: state_d = S_FETCH_1;
            S_FETCH_1: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                opc_d    = dec_opc;
                a_d      = dec_a;
                b_d      = dec_b;
                target_d = dec_a;
                case (dec_opc)
                    OP_NOP:  state_d = S_FETCH_0;
                    OP_LDI:  state_d = S_WB;
                    OP_MOV:  state_d = S_RD;
                    OP_JMP:  state_d = S_JUMP;
                    OP_CALL: begin
                        if (sp_q == SP_W'(STACK_DEPTH)) begin
                            state_d = S_FAULT;
                        end else begin
                            stack_d[push_idx] = pc_val;
                            sp_d    = sp_q + SP_W'(1);
                            state_d = S_JUMP;
                        end
                    end
                    OP_RET: begin
                        if (sp_q == '0) begin
                            state_d = S_FAULT;
                        end else begin
                            target_d = stack_q[pop_idx];
                            sp_d     = sp_q - SP_W'(1);
                            state_d  = S_JUMP;
                        end
                    end
                    OP_JZ:   state_d = flag_z ? S_JUMP : S_FETCH_0;
                    OP_JNZ:  state_d = !flag_z ? S_JUMP : S_FETCH_0;
                    OP_JG:   state_d = (!flag_z && (flag_n == flag_v)) ? S_JUMP : S_FETCH_0;
                    OP_JL:   state_d = (flag_n ^ flag_v) ? S_JUMP : S_FETCH_0;
                    OP_HALT: state_d = S_HALT;
                    default: state_d = is_alu(dec_opc) ? S_RD : S_FAULT;
                endcase
            end
            S_RD:    state_d = (opc_q == OP_MOV) ? S_WB : S_EX;
            S_EX:    state_d = S_WB;
            S_WB:    state_d = S_FETCH_0;
            S_JUMP:  state_d = S_FETCH_0;
            S_HALT:  state_d = S_HALT;
            S_FAULT: state_d = S_FAULT;
            default: state_d = S_FAULT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH_0;
            opc_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            target_q <= '0;
            sp_q     <= '0;
            stack_q  <= '{default: '0};
        end else begin
            state_q  <= state_d;
            opc_q    <= opc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            target_q <= target_d;
            sp_q     <= sp_d;
            stack_q  <= stack_d;
        end
    end

    // Outputs are gated by rst so an aborted instruction issues no further strobes.
    always_comb begin
        mar_load    = 1'b0;
        ir_load     = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        pc_load_val = '0;
        reg_rd_en   = 1'b0;
        rd_addr1    = '0;
        rd_addr2    = '0;
        reg_wr_en   = 1'b0;
        wr_addr     = '0;
        wr_sel      = 2'd0;
        wr_imm      = '0;
        alu_en      = 1'b0;
        alu_sel     = '0;
        halted      = 1'b0;
        fault       = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH_0: mar_load = 1'b1;
                S_FETCH_1: begin
                    ir_load = mem_ready;
                    pc_inc  = mem_ready;
                end
                S_RD: begin
                    reg_rd_en = 1'b1;
                    rd_addr1  = (opc_q == OP_MOV) ? b_q : a_q;
                    rd_addr2  = b_q;
                end
                S_EX: begin
                    alu_en  = 1'b1;
                    alu_sel = opc_q;
                end
                S_WB: begin
                    reg_wr_en = (opc_q != OP_CMP);
                    wr_addr   = a_q;
                    wr_imm    = b_q;
                    if (opc_q == OP_LDI) begin
                        wr_sel = 2'd0;
                    end else if (opc_q == OP_MOV) begin
                        wr_sel = 2'd1;
                    end else begin
                        // ALU function stays selected while its result is written back.
                        wr_sel  = 2'd2;
                        alu_sel = opc_q;
                    end
                end
                S_JUMP: begin
                    pc_load     = 1'b1;
                    pc_load_val = target_q;
                end
                S_HALT:  halted = 1'b1;
                S_FAULT: fault  = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - per-cycle trace model check of control_sequencer
module tb_control_sequencer;
    typedef struct packed {
        logic       rst;
        logic [23:0] iw;
        logic       mr;
        logic [3:0] fl;
        logic [7:0] pcv;
    } in_t;

    typedef struct packed {
        logic       mar_load, ir_load, pc_inc, pc_load;
        logic [7:0] pc_load_val;
        logic       reg_rd_en;
        logic [7:0] rd_addr1, rd_addr2;
        logic       reg_wr_en;
        logic [7:0] wr_addr;
        logic [1:0] wr_sel;
        logic [7:0] wr_imm;
        logic       alu_en;
        logic [7:0] alu_sel;
        logic       halted, fault;
    } out_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] instr_word = '0;
    logic        mem_ready = 1'b0;
    logic [3:0]  flags = '0;
    logic [7:0]  pc_val = '0;
    out_t        act, exp_o;
    logic        chk = 1'b0;
    int          n_cmp = 0, n_bad = 0, cyc = 0;

    in_t         tin[$];
    out_t        tout[$];
    logic [7:0]  stk[$];
    logic [7:0]  seen_pcl[$];
    int          mode = 0;

    always #5 clk = ~clk;

    control_sequencer #(.DATA_W(8), .OPC_W(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .instr_word(instr_word), .mem_ready(mem_ready),
        .flags(flags), .pc_val(pc_val),
        .mar_load(act.mar_load), .ir_load(act.ir_load), .pc_inc(act.pc_inc),
        .pc_load(act.pc_load), .pc_load_val(act.pc_load_val),
        .reg_rd_en(act.reg_rd_en), .rd_addr1(act.rd_addr1), .rd_addr2(act.rd_addr2),
        .reg_wr_en(act.reg_wr_en), .wr_addr(act.wr_addr), .wr_sel(act.wr_sel),
        .wr_imm(act.wr_imm), .alu_en(act.alu_en), .alu_sel(act.alu_sel),
        .halted(act.halted), .fault(act.fault)
    );

    always @(negedge clk) begin
        if (chk) begin
            cyc++;
            n_cmp++;
            if (act !== exp_o) begin
                n_bad++;
                $display("FAIL outputs cyc=%0d got=%h exp=%h", cyc, act, exp_o);
            end
            if (act.pc_load) seen_pcl.push_back(act.pc_load_val);
        end
    end

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", nm, got, want);
        end
    endtask

    function automatic in_t rnd_in();
        in_t i;
        i.rst = 1'b0;
        i.iw  = 24'($urandom);
        i.mr  = 1'($urandom);
        i.fl  = 4'($urandom);
        i.pcv = 8'($urandom);
        return i;
    endfunction

    function automatic out_t idle_out();
        out_t o = '0;
        o.halted = (mode == 1);
        o.fault  = (mode == 2);
        return o;
    endfunction

    task automatic add(input in_t i, input out_t o);
        tin.push_back(i);
        tout.push_back(o);
    endtask

    task automatic do_reset(input int n);
        in_t i;
        for (int k = 0; k < n; k++) begin
            i = rnd_in();
            i.rst = 1'b1;
            add(i, '0);
        end
        mode = 0;
        stk.delete();
    endtask

    // Expected trace of one instruction, derived from the instruction-class rules.
    task automatic build(input logic [7:0] opc, input logic [7:0] a, input logic [7:0] b,
                         input logic [3:0] fl, input logic [7:0] pcv, input int nwait,
                         output int len);
        in_t  i;
        out_t o;
        bit   jump = 0, stop = 0, z, n, v, taken;
        logic [7:0] tgt = a;
        int   start = tout.size();
        if (mode != 0) begin
            for (int k = 0; k < 3; k++) add(rnd_in(), idle_out());
            len = 3;
            return;
        end
        o = '0; o.mar_load = 1; add(rnd_in(), o);
        for (int k = 0; k < nwait; k++) begin
            i = rnd_in(); i.mr = 0; add(i, '0);
        end
        i = rnd_in(); i.mr = 1;
        o = '0; o.ir_load = 1; o.pc_inc = 1; add(i, o);
        i = rnd_in(); i.iw = {opc, a, b}; i.fl = fl; i.pcv = pcv; add(i, '0);
        z = fl[0]; n = fl[2]; v = fl[3];
        if (opc == 8'h00) begin
        end else if (opc == 8'h01) begin
            o = '0; o.reg_wr_en = 1; o.wr_addr = a; o.wr_sel = 0; o.wr_imm = b; add(rnd_in(), o);
        end else if (opc == 8'h20) begin
            o = '0; o.reg_rd_en = 1; o.rd_addr1 = b; o.rd_addr2 = b; add(rnd_in(), o);
            o = '0; o.reg_wr_en = 1; o.wr_addr = a; o.wr_sel = 1; o.wr_imm = b; add(rnd_in(), o);
        end else if (opc >= 8'h03 && opc <= 8'h18) begin
            o = '0; o.reg_rd_en = 1; o.rd_addr1 = a; o.rd_addr2 = b; add(rnd_in(), o);
            o = '0; o.alu_en = 1; o.alu_sel = opc; add(rnd_in(), o);
            o = '0; o.reg_wr_en = (opc != 8'h18); o.wr_addr = a; o.wr_sel = 2; o.wr_imm = b;
            o.alu_sel = opc; add(rnd_in(), o);
        end else if (opc == 8'h19) begin
            jump = 1;
        end else if (opc == 8'h21) begin
            if (stk.size() == 4) stop = 1;
            else begin stk.push_back(pcv); jump = 1; end
        end else if (opc == 8'h22) begin
            if (stk.size() == 0) stop = 1;
            else begin tgt = stk.pop_back(); jump = 1; end
        end else if (opc >= 8'h23 && opc <= 8'h26) begin
            case (opc)
                8'h23:   taken = z;
                8'h24:   taken = !z;
                8'h25:   taken = !z && (n == v);
                default: taken = n ^ v;
            endcase
            jump = taken;
        end else if (opc == 8'h3F) begin
            mode = 1;
            for (int k = 0; k < 2; k++) add(rnd_in(), idle_out());
        end else begin
            stop = 1;
        end
        if (stop) begin
            mode = 2;
            for (int k = 0; k < 2; k++) add(rnd_in(), idle_out());
        end
        if (jump) begin
            o = '0; o.pc_load = 1; o.pc_load_val = tgt; add(rnd_in(), o);
        end
        len = tout.size() - start;
    endtask

    task automatic play();
        in_t i;
        while (tout.size() > 0) begin
            i          = tin.pop_front();
            exp_o      = tout.pop_front();
            rst        = i.rst;
            instr_word = i.iw;
            mem_ready  = i.mr;
            flags      = i.fl;
            pc_val     = i.pcv;
            chk        = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int len;
        logic [7:0] opc;
        repeat (2) @(posedge clk);
        #1;
        do_reset(3);
        build(8'h01, 8'h05, 8'h2A, 4'h0, 8'h00, 0, len);
        check("ldi_len", len, 4);
        check("ldi_wb_wr_en", tout[6].reg_wr_en, 1);
        check("ldi_wb_addr", tout[6].wr_addr, 8'h05);
        check("ldi_wb_imm", tout[6].wr_imm, 8'h2A);
        play();

        build(8'h03, 8'h02, 8'h03, 4'h0, 8'h00, 2, len);
        check("add_len", len, 8);
        check("add_no_early_ir", tout[1].ir_load, 0);
        check("add_ir_when_ready", tout[3].ir_load, 1);
        check("add_wb_sel", tout[7].wr_sel, 2);
        check("add_wb_alu_sel", tout[7].alu_sel, 8'h03);
        play();

        build(8'h18, 8'h01, 8'h02, 4'h0, 8'h00, 0, len);
        check("cmp_len", len, 6);
        check("cmp_alu_en", tout[4].alu_en, 1);
        check("cmp_no_wr", tout[5].reg_wr_en, 0);
        play();
        build(8'h23, 8'h40, 8'h00, 4'h1, 8'h00, 0, len);
        check("jz_taken_len", len, 4);
        check("jz_target", tout[3].pc_load_val, 8'h40);
        play();
        build(8'h23, 8'h40, 8'h00, 4'h0, 8'h00, 0, len);
        check("jz_not_taken_len", len, 3);
        play();

        for (int f = 0; f < 16; f++) begin
            build(8'h25, 8'h60, 8'h00, 4'(f), 8'h00, 0, len);
            build(8'h26, 8'h70, 8'h00, 4'(f), 8'h00, 0, len);
        end
        play();

        for (int k = 0; k < 4; k++) build(8'h21, 8'h80, 8'h00, 4'h0, 8'(8'h11 + k), 0, len);
        play();
        seen_pcl.delete();
        build(8'h21, 8'h80, 8'h00, 4'h0, 8'h15, 0, len);
        play();
        check("call_full_no_pc_load", seen_pcl.size(), 0);
        check("call_full_fault", act.fault, 1);
        do_reset(2);
        for (int k = 0; k < 4; k++) build(8'h21, 8'h80, 8'h00, 4'h0, 8'(8'h11 + k), 0, len);
        play();
        seen_pcl.delete();
        for (int k = 0; k < 4; k++) build(8'h22, 8'h00, 8'h00, 4'h0, 8'h00, 0, len);
        play();
        check("ret_count", seen_pcl.size(), 4);
        for (int k = 0; k < 4 && k < seen_pcl.size(); k++)
            check("ret_order", seen_pcl[k], 8'(8'h14 - k));
        build(8'h22, 8'h00, 8'h00, 4'h0, 8'h00, 0, len);
        play();
        check("ret_empty_fault", act.fault, 1);

        do_reset(1);
        build(8'h7E, 8'h00, 8'h00, 4'h0, 8'h00, 0, len);
        build(8'h01, 8'h01, 8'h01, 4'h0, 8'h00, 0, len);
        play();
        check("fault_sticky", act.fault, 1);
        do_reset(2);
        build(8'h3F, 8'h00, 8'h00, 4'h0, 8'h00, 1, len);
        build(8'h19, 8'h33, 8'h00, 4'h0, 8'h00, 0, len);
        play();
        check("halted", act.halted, 1);

        do_reset(1);
        build(8'h05, 8'h09, 8'h0A, 4'h0, 8'h00, 0, len);
        void'(tin.pop_back()); void'(tout.pop_back());
        void'(tin.pop_back()); void'(tout.pop_back());
        do_reset(1);
        build(8'h01, 8'h07, 8'h08, 4'h0, 8'h00, 0, len);
        play();

        for (int t = 0; t < 400; t++) begin
            case ($urandom_range(0, 11))
                0:       opc = 8'h00;
                1:       opc = 8'h01;
                2:       opc = 8'h20;
                3:       opc = 8'($urandom_range(3, 24));
                4:       opc = 8'h18;
                5:       opc = 8'h19;
                6, 11:   opc = 8'h21;
                7:       opc = 8'h22;
                8, 9:    opc = 8'($urandom_range(35, 38));
                default: opc = ($urandom_range(0, 3) == 0) ? 8'h3F : 8'($urandom);
            endcase
            build(opc, 8'($urandom), 8'($urandom), 4'($urandom), 8'($urandom),
                  $urandom_range(0, 2), len);
            if (mode != 0) do_reset($urandom_range(1, 3));
            play();
        end

        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
